// File: rtl/expr_stream_collector.sv
// Issue/collect front end for a fixed-latency, non-stallable expr pipeline.
// Operands are issued only when a result FIFO slot is reserved, so results are never lost.
module expr_stream_collector #(
    parameter int PIPE_LAT = 37,
    parameter int DEPTH    = 8,
    parameter int W        = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] pipe_x,
    input  logic [W-1:0] pipe_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PIPE_LAT:0] tok;
    logic [W-1:0]      mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic              reset_q;
    logic              accept;
    logic              capture;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic [CW:0]       used;

    // A slot is owned either by a token still in the pipe or by a stored result.
    always_comb begin
        used      = {1'b0, inflight} + {1'b0, count};
        in_ready  = !reset_q && (used < (CW+1)'(DEPTH));
        out_valid = (count != '0);
        out_data  = mem[head];
        busy      = (inflight != '0) || (count != '0);
        accept    = in_valid && in_ready;
        capture   = tok[PIPE_LAT];
        pop       = out_valid && out_ready;
        full      = (count == CW'(DEPTH));
        wr_en     = capture && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reset_q  <= 1'b1;
            tok      <= '0;
            pipe_x   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            reset_q <= 1'b0;
            tok     <= {tok[PIPE_LAT-1:0], accept};
            pipe_x  <= accept ? in_data : '0;

            if (wr_en)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);

            if (wr_en && !pop)
                count <= count + CW'(1);
            else if (pop && !wr_en)
                count <= count - CW'(1);

            // The token retires on capture even if its result had nowhere to go.
            if (accept && !capture)
                inflight <= inflight + CW'(1);
            else if (capture && !accept)
                inflight <= inflight - CW'(1);

            if (capture && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[tail] <= pipe_result;
        end
    end

endmodule

// File: tb/tb_expr_stream_collector.sv
// Directed and randomised checks of expr_stream_collector against a +1.0f stub pipeline.
module tb_expr_stream_collector;
    localparam int PIPE_LAT = 4;
    localparam int DEPTH    = 4;
    localparam int W        = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] pipe_x;
    logic [W-1:0] pipe_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] dly [PIPE_LAT];

    expr_stream_collector #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_x(pipe_x), .pipe_result(pipe_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Single/double conversion for normal values; integers below 2^24 stay exact.
    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'h0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'h0) return 64'h0;
        e = {3'b0, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'h0};
    endfunction

    function automatic logic [31:0] itof(input int k);
        return d2s($realtobits(real'(k)));
    endfunction

    function automatic logic [31:0] add1(input logic [31:0] s);
        return d2s($realtobits($bitstoreal(s2d(s)) + 1.0));
    endfunction

    initial for (int i = 0; i < PIPE_LAT; i++) dly[i] = '0;

    always @(posedge clk) begin
        dly[0] <= pipe_x;
        for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
    end

    assign pipe_result = add1(dly[PIPE_LAT-1]);

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (pipe_x !== 32'h0) begin errors++; $display("FAIL reset_pipe_x: got %h want 0", pipe_x); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        int lat;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        checks++; if (pipe_x !== 32'h40000000) begin errors++; $display("FAIL single_pipe_x: got %h want 40000000", pipe_x); end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", lat); end
        checks++; if (out_data !== 32'h40400000) begin errors++; $display("FAIL single_data: got %h want 40400000", out_data); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, cyc;
        logic acc, pp;
        sent = 0; got = 0; cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = itof(10);
        while ((sent < 10 || got < 10) && cyc < 200) begin
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            if (pp) begin
                checks++;
                if (out_data !== itof(11 + got)) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %h want %h", got, out_data, itof(11 + got));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            in_valid = (sent < 10);
            in_data  = itof(10 + sent);
        end
        in_valid = 1'b0;
        checks++; if (sent !== 10 || got !== 10) begin errors++; $display("FAIL b2b_count: got sent=%0d out=%0d want 10 10", sent, got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_fill();
        int sent;
        logic acc;
        sent = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = itof(100);
        repeat (20) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            in_data = itof(100 + sent);
        end
        checks++; if (sent !== 4) begin errors++; $display("FAIL fill_accepts: got %0d want 4", sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== itof(101)) begin errors++; $display("FAIL fill_head: got %h want %h", out_data, itof(101)); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_pop_one();
        int sent, n, cyc;
        int expv [4];
        logic acc;
        expv = '{102, 103, 104, 201};
        in_valid = 1'b1; in_data = itof(200);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pop1_pre_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_data !== itof(102)) begin errors++; $display("FAIL pop1_head: got %h want %h", out_data, itof(102)); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop1_ready_rise: got %b want 1", in_ready); end
        sent = 0;
        repeat (20) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checks++; if (sent !== 1) begin errors++; $display("FAIL pop1_accepts: got %0d want 1", sent); end
        n = 0; cyc = 0;
        out_ready = 1'b1;
        while (n < 4 && cyc < 30) begin
            if (out_valid) begin
                checks++;
                if (out_data !== itof(expv[n])) begin
                    errors++; $display("FAIL pop1_drain[%0d]: got %h want %h", n, out_data, itof(expv[n]));
                end
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (n !== 4 || busy !== 1'b0) begin errors++; $display("FAIL pop1_drain_done: got n=%0d busy=%b want 4 0", n, busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pop1_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b0; in_valid = 1'b1; in_data = itof(300);
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready_low: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_cleared: got busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready_high: got %b want 1", in_ready); end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_capture: got %0d active cycles want 0", seen); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_random();
        logic [31:0] expq [$];
        logic acc, pp;
        int k, cyc;
        k = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            k         = int'($urandom_range(0, 5000));
            in_data   = itof(k);
            #1;
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            if (pp) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: got %h want no output", out_data);
                end else begin
                    if (out_data !== expq[0]) begin
                        errors++; $display("FAIL rand_data: got %h want %h", out_data, expq[0]);
                    end
                    void'(expq.pop_front());
                end
            end
            if (acc) expq.push_back(itof(k + 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (busy && cyc < 100) begin
            if (out_valid) begin
                checks++;
                if (expq.size() == 0 || out_data !== expq[0]) begin
                    errors++; $display("FAIL rand_drain: got %h want %h", out_data, (expq.size() != 0) ? expq[0] : 32'h0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (expq.size() !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rand_leftover: got %0d pending busy=%b want 0 0", expq.size(), busy);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_pop_one();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
